// File: rtl/monitor_pkg.sv
// Shared types and default parameters for the retirement monitor and later core variants.
`default_nettype none

package monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  localparam int DEF_PC_W           = 32;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_TRACE_DEPTH    = 8;
  localparam int DEF_HALT_REPEAT    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  function automatic logic is_terminal(input mon_state_e s);
    return (s == HALTED) || (s == TIMEOUT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_ring.sv
// Circular PC store with saturating fill count and newest-relative, masked read port.
`default_nettype none

module trace_ring #(
  parameter  int PC_W  = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_data,
  input  logic [AW-1:0]   rd_idx,
  output logic [AW:0]     fill,
  output logic [PC_W-1:0] rd_data
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rd_addr;

  // Storage has no reset; stale contents are hidden by the fill-count mask.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      fill <= '0;
    end else if (wr_en) begin
      wptr <= wptr + AW'(1);
      if (fill != FULL) begin
        fill <= fill + (AW+1)'(1);
      end
    end
  end

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign rd_addr = wptr - AW'(1) - rd_idx;
  assign rd_data = ({1'b0, rd_idx} < fill) ? mem[rd_addr] : '0;

endmodule

`default_nettype wire

// File: rtl/commit_monitor.sv
// Retirement monitor: run/halt/timeout FSM, cycle and retire counters, self-loop detection
// and a PC trace ring.
`default_nettype none

module commit_monitor
  import monitor_pkg::*;
#(
  parameter int PC_W           = DEF_PC_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRACE_DEPTH    = DEF_TRACE_DEPTH,
  parameter int HALT_REPEAT    = DEF_HALT_REPEAT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [PC_W-1:0]                i_pc_debug,
  input  logic                           i_insn_vld,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_idx,
  output logic [1:0]                     o_state,
  output logic                           o_done,
  output logic [CNT_W-1:0]               o_cycle_cnt,
  output logic [CNT_W-1:0]               o_retire_cnt,
  output logic [$clog2(TRACE_DEPTH):0]   o_trace_cnt,
  output logic [PC_W-1:0]                o_trace_pc
);

  localparam int                REP_W       = $clog2(HALT_REPEAT) + 1;
  localparam logic [REP_W-1:0]  HALT_REP    = REP_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  mon_state_e       state, state_nx;
  logic [CNT_W-1:0] cycle_cnt, cycle_nx;
  logic [CNT_W-1:0] retire_cnt, retire_nx;
  logic [REP_W-1:0] rep, rep_nx;
  logic [PC_W-1:0]  last_pc, last_pc_nx;
  logic             active;
  logic             retire;
  logic             hit_halt;
  logic             hit_timeout;

  assign active = (state == IDLE) || (state == RUN);
  assign retire = active && i_insn_vld;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      rep        <= '0;
      last_pc    <= '0;
    end else begin
      cycle_cnt  <= cycle_nx;
      retire_cnt <= retire_nx;
      rep        <= rep_nx;
      last_pc    <= last_pc_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cycle_nx    = cycle_cnt;
    retire_nx   = retire_cnt;
    rep_nx      = rep;
    last_pc_nx  = last_pc;
    hit_halt    = 1'b0;
    hit_timeout = 1'b0;

    if (active) begin
      if (cycle_cnt != CNT_MAX) begin
        cycle_nx = cycle_cnt + CNT_W'(1);
      end
      hit_timeout = (cycle_nx == TIMEOUT_VAL);
    end

    if (retire) begin
      if (retire_cnt != CNT_MAX) begin
        retire_nx = retire_cnt + CNT_W'(1);
      end
      // A nonzero retire count keeps the reset value of last_pc from matching a PC of 0.
      if ((i_pc_debug == last_pc) && (retire_cnt != '0)) begin
        rep_nx = rep + REP_W'(1);
      end else begin
        rep_nx = '0;
      end
      last_pc_nx = i_pc_debug;
      hit_halt   = (rep_nx == HALT_REP);
    end

    if (hit_halt) begin
      state_nx = HALTED;
    end else if (hit_timeout) begin
      state_nx = TIMEOUT;
    end else if (retire && (state == IDLE)) begin
      state_nx = RUN;
    end
  end

  trace_ring #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_ring (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (retire),
    .wr_data (i_pc_debug),
    .rd_idx  (i_trace_idx),
    .fill    (o_trace_cnt),
    .rd_data (o_trace_pc)
  );

  assign o_state      = state;
  assign o_done       = is_terminal(state);
  assign o_cycle_cnt  = cycle_cnt;
  assign o_retire_cnt = retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: vector table through a scoreboard queue plus
// hand-written timeout and halt/timeout collision sequences.
`default_nettype none

module tb_commit_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [31:0] pc;
  logic [2:0]  idx;

  logic [1:0]  st_a, st_b;
  logic        done_a, done_b;
  logic [31:0] cyc_a, cyc_b, ret_a, ret_b, tpc_a, tpc_b;
  logic [3:0]  tcnt_a, tcnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  commit_monitor #(.TIMEOUT_CYCLES(20)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc_debug(pc), .i_insn_vld(vld), .i_trace_idx(idx),
    .o_state(st_a), .o_done(done_a), .o_cycle_cnt(cyc_a), .o_retire_cnt(ret_a),
    .o_trace_cnt(tcnt_a), .o_trace_pc(tpc_a)
  );

  commit_monitor #(.TIMEOUT_CYCLES(10)) dut10 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc_debug(pc), .i_insn_vld(vld), .i_trace_idx(idx),
    .o_state(st_b), .o_done(done_b), .o_cycle_cnt(cyc_b), .o_retire_cnt(ret_b),
    .o_trace_cnt(tcnt_b), .o_trace_pc(tpc_b)
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  idx;
    logic [1:0]  st;
    int          cyc;
    int          ret;
    int          tcnt;
    logic [31:0] tpc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] p,
                              input logic [2:0] i, input logic [1:0] s, input int c,
                              input int rt, input int tc, input logic [31:0] tp);
    vec_t x;
    x.rst_n = r; x.vld = v; x.pc = p; x.idx = i; x.st = s;
    x.cyc = c; x.ret = rt; x.tcnt = tc; x.tpc = tp;
    return x;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [31:0] p, input logic [2:0] i);
    rst_n = r; vld = v; pc = p; idx = i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    logic [31:0] hist [8];
    int n;

    drive(1'b0, 1'b0, 32'h0, 3'd0);

    // Reset held with a retirement presented: everything reads zero.
    tbl.push_back(mk(0, 1, 32'h55, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h55, 7, 0, 0, 0, 0, 32'h0));
    // Five distinct PCs then the self-loop PC four times.
    tbl.push_back(mk(1, 1, 32'h00, 0, 1, 1, 1, 1, 32'h00));
    tbl.push_back(mk(1, 1, 32'h04, 0, 1, 2, 2, 2, 32'h04));
    tbl.push_back(mk(1, 1, 32'h08, 0, 1, 3, 3, 3, 32'h08));
    tbl.push_back(mk(1, 1, 32'h0C, 0, 1, 4, 4, 4, 32'h0C));
    tbl.push_back(mk(1, 1, 32'h10, 0, 1, 5, 5, 5, 32'h10));
    tbl.push_back(mk(1, 1, 32'h14, 0, 1, 6, 6, 6, 32'h14));
    tbl.push_back(mk(1, 1, 32'h14, 0, 1, 7, 7, 7, 32'h14));
    tbl.push_back(mk(1, 1, 32'h14, 0, 1, 8, 8, 8, 32'h14));
    tbl.push_back(mk(1, 1, 32'h14, 0, 2, 9, 9, 8, 32'h14));
    // Frozen after halt; walk the whole trace.
    hist = '{32'h14, 32'h14, 32'h14, 32'h14, 32'h10, 32'h0C, 32'h08, 32'h04};
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1, 1, 32'h99, 3'(i), 2, 9, 9, 8, hist[i]));
    end
    // Partial trace, then mid-run reset with a repeat run in progress.
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'h100, 0, 1, 1, 1, 1, 32'h100));
    tbl.push_back(mk(1, 1, 32'h104, 0, 1, 2, 2, 2, 32'h104));
    tbl.push_back(mk(1, 1, 32'h108, 0, 1, 3, 3, 3, 32'h108));
    tbl.push_back(mk(1, 0, 32'h0,   2, 1, 4, 3, 3, 32'h100));
    tbl.push_back(mk(1, 0, 32'h0,   5, 1, 5, 3, 3, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,   3, 1, 6, 3, 3, 32'h0));
    tbl.push_back(mk(1, 1, 32'h200, 0, 1, 7, 4, 4, 32'h200));
    tbl.push_back(mk(1, 1, 32'h200, 0, 1, 8, 5, 5, 32'h200));
    tbl.push_back(mk(1, 1, 32'h200, 1, 1, 9, 6, 6, 32'h200));
    tbl.push_back(mk(0, 1, 32'h200, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'h200, 0, 1, 1, 1, 1, 32'h200));
    tbl.push_back(mk(1, 1, 32'h200, 0, 1, 2, 2, 2, 32'h200));
    tbl.push_back(mk(1, 1, 32'h200, 0, 1, 3, 3, 3, 32'h200));
    tbl.push_back(mk(1, 1, 32'h200, 0, 2, 4, 4, 4, 32'h200));

    foreach (tbl[k]) begin
      drive(tbl[k].rst_n, tbl[k].vld, tbl[k].pc, tbl[k].idx);
      exp_q.push_back(tbl[k]);
      step();
      e = exp_q.pop_front();
      chk($sformatf("v%0d.state", k),  64'(st_a),   64'(e.st));
      chk($sformatf("v%0d.done", k),   64'(done_a), 64'(e.st[1]));
      chk($sformatf("v%0d.cycle", k),  64'(cyc_a),  64'(e.cyc));
      chk($sformatf("v%0d.retire", k), 64'(ret_a),  64'(e.ret));
      chk($sformatf("v%0d.tcnt", k),   64'(tcnt_a), 64'(e.tcnt));
      chk($sformatf("v%0d.tpc", k),    64'(tpc_a),  64'(e.tpc));
    end

    // Watchdog: incrementing PC every cycle, bounded wait for done.
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    step();
    n = 0;
    while (!done_a && n < 40) begin
      drive(1'b1, 1'b1, 32'(n * 4), 3'd0);
      step();
      n++;
      if (n == 19) begin
        chk("to.pre_state", 64'(st_a), 64'd1);
        chk("to.pre_cycle", 64'(cyc_a), 64'd19);
      end
    end
    chk("to.done_reached", 64'(done_a), 64'd1);
    chk("to.edges", 64'(n), 64'd20);
    chk("to.state", 64'(st_a), 64'd3);
    chk("to.cycle", 64'(cyc_a), 64'd20);
    chk("to.retire", 64'(ret_a), 64'd20);
    chk("to10.state", 64'(st_b), 64'd3);
    chk("to10.cycle", 64'(cyc_b), 64'd10);
    chk("to10.retire", 64'(ret_b), 64'd10);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h500, 3'd0);
      step();
    end
    chk("to.hold_cycle", 64'(cyc_a), 64'd20);
    chk("to.hold_retire", 64'(ret_a), 64'd20);
    chk("to.hold_state", 64'(st_a), 64'd3);

    // Collision: fourth repeat lands on the edge where the 10-cycle watchdog fires.
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    step();
    for (int c = 1; c <= 10; c++) begin
      drive(1'b1, 1'b1, (c <= 6) ? 32'((c - 1) * 4) : 32'h40, 3'd0);
      step();
      if (c == 9) begin
        chk("col.pre_state", 64'(st_b), 64'd1);
        chk("col.pre_cycle", 64'(cyc_b), 64'd9);
      end
    end
    chk("col.state", 64'(st_b), 64'd2);
    chk("col.done", 64'(done_b), 64'd1);
    chk("col.cycle", 64'(cyc_b), 64'd10);
    chk("col.retire", 64'(ret_b), 64'd10);
    chk("col.tpc", 64'(tpc_b), 64'h40);
    chk("col20.state", 64'(st_a), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_monitor.md
# commit_monitor

Parametrised retirement monitor for the single-cycle RV32I core and its successors. It watches the core's debug PC and instruction-valid outputs and keeps cycle and retired-instruction counters. It also holds a circular PC trace buffer, detects the self-loop end-of-program idiom (`jal x0, 0`), and enforces a cycle watchdog. It replaces fixed-time simulation termination and can also be synthesised onto the FPGA, where it drives status LEDs and HEX readout.

## Interface
- PC_W, 32, PC width
- CNT_W, 32, counter width (cycle and retire)
- TRACE_DEPTH, 8, trace entries; power of two, ≥2
- HALT_REPEAT, 4, consecutive identical retired PCs that declare halt; ≥2
- TIMEOUT_CYCLES, 1000, watchdog limit in cycles; ≥2, < 2^CNT_W
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_pc_debug  in  PC_W  PC of the instruction retiring this cycle
- i_insn_vld  in  1  retirement strobe for i_pc_debug
- i_trace_idx  in  $clog2(TRACE_DEPTH)  trace read index; 0 = most recent
- o_state  out  2  IDLE=0, RUN=1, HALTED=2, TIMEOUT=3
- o_done  out  1  state is HALTED or TIMEOUT
- o_cycle_cnt  out  CNT_W  cycles elapsed in IDLE/RUN
- o_retire_cnt  out  CNT_W  retired instructions
- o_trace_cnt  out  $clog2(TRACE_DEPTH)+1  valid trace entries, saturates at TRACE_DEPTH
- o_trace_pc  out  PC_W  trace entry at i_trace_idx

## Operation
- Reset (i_rst_n=0 at an edge) sets every register to 0: state IDLE, all counters, trace write pointer, repeat counter and last-PC. Trace storage contents are don't-care, but reads are masked (see below).
- IDLE: no instruction retired yet. The first i_insn_vld moves the state to RUN.
- RUN: normal operation. Leaves only to HALTED or TIMEOUT.
- HALTED and TIMEOUT are terminal. They are held until reset. No counter or trace updates occur in either state.
- Cycle counter: +1 every cycle while the state is IDLE or RUN.
- Retire counter: +1 on every i_insn_vld while the state is IDLE or RUN.
- Both counters saturate at 2^CNT_W−1.
- Repeat detection, on each valid retirement:
  - if i_pc_debug equals last-PC and the retire counter is nonzero, rep = rep+1; otherwise rep = 0.
  - last-PC takes i_pc_debug.
  - The state goes to HALTED on the retirement that makes rep = HALT_REPEAT−1, i.e. the HALT_REPEAT-th consecutive identical PC. That retirement is counted and traced.
- Watchdog: the state goes to TIMEOUT at the edge where the cycle counter would reach TIMEOUT_CYCLES. The counter holds TIMEOUT_CYCLES afterwards.
- If halt and timeout occur on the same edge, HALTED wins.
- Trace buffer:
  - Each counted retirement writes i_pc_debug at wptr, then wptr = (wptr+1) mod TRACE_DEPTH. Overwrite of the oldest entry on wrap is silent.
  - o_trace_cnt = min(retirements, TRACE_DEPTH).
  - Read address = (wptr−1−i_trace_idx) mod TRACE_DEPTH.
  - o_trace_pc = 0 when i_trace_idx ≥ o_trace_cnt.
- i_pc_debug is ignored when i_insn_vld=0.

## Timing
- All outputs except o_trace_pc are registered. A retirement sampled at edge k is reflected from edge k onward, i.e. visible in cycle k+1.
- o_trace_pc is combinational from i_trace_idx and registered storage, with zero-cycle read latency. It has no path from i_pc_debug.
- Reset mid-run takes effect at the next edge with i_rst_n=0, including from terminal states. A retirement presented in that cycle is discarded.
- The first cycle after reset release is IDLE with o_cycle_cnt=0. A retirement in that cycle gives state RUN, cycle_cnt=1 and retire_cnt=1 at the next edge.

## Structure
- The shared package `monitor_pkg` holds the `mon_state_e` enum (IDLE, RUN, HALTED, TIMEOUT) and the default parameter constants. Later core variants import it.
- Sub-module `trace_ring`: parametrised PC_W × TRACE_DEPTH circular store with write pointer, saturating fill count and newest-relative masked read. `commit_monitor` contains the FSM, counters and repeat logic.
- The top-level bench instantiates `commit_monitor` and terminates simulation on o_done.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with i_insn_vld=1 → all outputs 0, state IDLE, o_trace_pc=0 for all indices.
- Halt: retire 0x00, 0x04, 0x08, 0x0C, 0x10, then 0x14 four times (HALT_REPEAT=4, DEPTH=8) → HALTED after the 9th retirement. Expect retire_cnt=9 and trace idx0..7 = 14,14,14,14,10,0C,08,04. Further vld pulses leave all values unchanged.
- Timeout: TIMEOUT_CYCLES=20, a retirement of an incrementing PC every cycle from reset release → TIMEOUT visible after edge 20. Expect cycle_cnt=20, retire_cnt=20, o_done=1.
- Partial trace: 3 retirements 0x100, 0x104, 0x108 → trace_cnt=3, idx0=0x108, idx2=0x100, idx5=0.
- Collision: TIMEOUT_CYCLES=10 with the 4th repeat landing on the edge where the counter hits 10 → HALTED.
- Mid-run reset: reset asserted in RUN after 6 retirements → next cycle IDLE with all counters 0. The sequence restarts correctly, including with repeat counts not carried over.
